exe_div_unit: RTL and testbench

EXE_DIV_UNIT -- requirements
Module: exe_div_unit

---
 rtl/exe_div_unit.sv | 125 ++++++++++++
 tb/tb_exe_div_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_div_unit.sv
// Multi-cycle restoring radix-2 divider for the EXE stage (DIV/DIVU).
// Holds the pipeline while iterating and keeps results until accepted.
module exe_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXE_Flush,
  input  logic        Div_Start,
  input  logic        Div_Signed,
  input  logic [31:0] Div_A,
  input  logic [31:0] Div_B,
  input  logic        Div_Ack,
  output logic        Div_Stall,
  output logic        Div_Busy,
  output logic        Div_Done,
  output logic [31:0] Div_Quot,
  output logic [31:0] Div_Rem
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] prem_q, prem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;

  logic        accept;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        borrow;
  logic [32:0] prem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] a_mag, b_mag;

  assign accept  = (state_q == IDLE) && Div_Start && !EXE_Flush;
  assign a_mag   = (Div_Signed && Div_A[31]) ? -Div_A : Div_A;
  assign b_mag   = (Div_Signed && Div_B[31]) ? -Div_B : Div_B;

  // Partial remainder stays below the divisor, so 33 bits hold the shift.
  assign shifted  = {prem_q[31:0], quo_q[31]};
  assign diff     = {1'b0, shifted} - {2'b00, dvs_q};
  assign borrow   = diff[33];
  assign prem_nxt = borrow ? shifted : diff[32:0];
  assign quo_nxt  = {quo_q[30:0], ~borrow};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    if (EXE_Flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Div_Start) begin
            state_d = CALC;
            cnt_d   = '0;
            prem_d  = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            // Zero divisor yields all-ones regardless of sign.
            negq_d  = Div_Signed && (Div_A[31] ^ Div_B[31])
                      && (Div_B != '0);
            negr_d  = Div_Signed && Div_A[31];
          end
        end
        CALC: begin
          cnt_d  = cnt_q + 6'd1;
          prem_d = prem_nxt;
          quo_d  = quo_nxt;
          if (cnt_q == 6'd31) begin
            state_d = DONE;
            quot_d  = negq_q ? -quo_nxt : quo_nxt;
            rem_d   = negr_q ? -prem_nxt[31:0] : prem_nxt[31:0];
          end
        end
        DONE: begin
          if (Div_Ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign Div_Busy  = (state_q == CALC);
  assign Div_Done  = (state_q == DONE);
  assign Div_Stall = !rst && (Div_Busy || accept);
  assign Div_Quot  = quot_q;
  assign Div_Rem   = rem_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// Self-checking bench for exe_div_unit: vector table, corner sequences
// and random operands against an arithmetic reference model.
module tb_exe_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        EXE_Flush;
  logic        Div_Start;
  logic        Div_Signed;
  logic [31:0] Div_A;
  logic [31:0] Div_B;
  logic        Div_Ack;
  logic        Div_Stall;
  logic        Div_Busy;
  logic        Div_Done;
  logic [31:0] Div_Quot;
  logic [31:0] Div_Rem;

  int n_chk  = 0;
  int n_fail = 0;

  exe_div_unit dut (
    .clk(clk), .rst(rst), .EXE_Flush(EXE_Flush),
    .Div_Start(Div_Start), .Div_Signed(Div_Signed),
    .Div_A(Div_A), .Div_B(Div_B), .Div_Ack(Div_Ack),
    .Div_Stall(Div_Stall), .Div_Busy(Div_Busy),
    .Div_Done(Div_Done), .Div_Quot(Div_Quot), .Div_Rem(Div_Rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void model(input bit sgn, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] q,
                                output logic [31:0] r);
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endfunction

  task automatic run_div(input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] q,
                         input logic [31:0] r, input int hold,
                         input string tag);
    int busy_n;
    int stall_n;
    Div_Start  = 1'b1;
    Div_Signed = sgn;
    Div_A      = a;
    Div_B      = b;
    Div_Ack    = 1'b0;
    #1;
    stall_n = Div_Stall ? 1 : 0;
    busy_n  = 0;
    @(negedge clk);
    while (Div_Busy && busy_n < 100) begin
      busy_n++;
      if (Div_Stall) stall_n++;
      Div_A      = $urandom;
      Div_B      = $urandom;
      Div_Signed = 1'($urandom);
      Div_Ack    = 1'($urandom);
      @(negedge clk);
    end
    Div_Ack = 1'b0;
    chk({tag, " busy_cycles"}, busy_n, 32);
    chk({tag, " stall_cycles"}, stall_n, 33);
    for (int i = 0; i <= hold; i++) begin
      chk({tag, " done"}, {31'b0, Div_Done}, 1);
      chk({tag, " stall_in_done"}, {31'b0, Div_Stall}, 0);
      chk({tag, " quot"}, Div_Quot, q);
      chk({tag, " rem"}, Div_Rem, r);
      if (i < hold) begin
        Div_A = $urandom;
        Div_B = $urandom;
        @(negedge clk);
      end
    end
    Div_Ack   = 1'b1;
    Div_Start = 1'b0;
    @(negedge clk);
    Div_Ack = 1'b0;
    chk({tag, " idle_done"}, {31'b0, Div_Done}, 0);
    chk({tag, " idle_busy"}, {31'b0, Div_Busy}, 0);
  endtask

  task automatic start_and_wait(input int cycles);
    Div_Start  = 1'b1;
    Div_Signed = 1'b0;
    Div_A      = 32'd1000;
    Div_B      = 32'd3;
    Div_Ack    = 1'b0;
    @(negedge clk);
    for (int i = 1; i < cycles; i++) @(negedge clk);
  endtask

  initial begin
    logic [31:0] q, r, a, b;
    bit sgn;
    int done_seen;

    vecs.push_back('{0, 32'd100, 32'd7, 32'd14, 32'd2});
    vecs.push_back('{1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
    vecs.push_back('{1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0});
    vecs.push_back('{0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5});
    vecs.push_back('{1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9});
    vecs.push_back('{0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1});
    vecs.push_back('{0, 32'd3, 32'd10, 32'd0, 32'd3});

    rst        = 1'b1;
    EXE_Flush  = 1'b0;
    Div_Start  = 1'b1;
    Div_Signed = 1'b0;
    Div_A      = 32'd100;
    Div_B      = 32'd7;
    Div_Ack    = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_stall", {31'b0, Div_Stall}, 0);
    chk("reset_busy", {31'b0, Div_Busy}, 0);
    chk("reset_done", {31'b0, Div_Done}, 0);
    chk("reset_quot", Div_Quot, 0);
    chk("reset_rem", Div_Rem, 0);
    Div_Start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
              0, $sformatf("vec%0d", i));

    // Result must hold while the ack is withheld.
    run_div(0, 32'd100, 32'd7, 32'd14, 32'd2, 3, "hold");

    // Flush in the middle of the iteration.
    start_and_wait(10);
    chk("flush_pre_busy", {31'b0, Div_Busy}, 1);
    EXE_Flush = 1'b1;
    @(negedge clk);
    chk("flush_busy", {31'b0, Div_Busy}, 0);
    chk("flush_done", {31'b0, Div_Done}, 0);
    chk("flush_wins_stall", {31'b0, Div_Stall}, 0);
    @(negedge clk);
    chk("flush_no_restart", {31'b0, Div_Busy}, 0);
    EXE_Flush = 1'b0;
    Div_Start = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (Div_Done || Div_Busy) done_seen++;
    end
    chk("flush_never_done", done_seen, 0);
    run_div(0, 32'd9, 32'd3, 32'd3, 32'd0, 0, "after_flush");

    // Asynchronous reset mid-iteration, with old results still visible.
    start_and_wait(20);
    chk("rst_pre_busy", {31'b0, Div_Busy}, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_busy", {31'b0, Div_Busy}, 0);
    chk("rst_async_done", {31'b0, Div_Done}, 0);
    chk("rst_async_stall", {31'b0, Div_Stall}, 0);
    chk("rst_async_quot", Div_Quot, 0);
    chk("rst_async_rem", Div_Rem, 0);
    @(negedge clk);
    Div_Start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    run_div(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, "after_rst");

    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 15));
        1: b = -32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      model(sgn, a, b, q, r);
      run_div(sgn, a, b, q, r, i % 2, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
